ctrl_seq: RTL and testbench

Parametrised, sequential control unit for the CSE141L core. It replaces the purely combinational decoder with a small FSM that:
- decodes the opcode class and drives all datapath enables;
- holds ALU flags in registers so conditional branches can use them;
- stalls the fetch unit on multi-cycle memory accesses, with a timeout-to-fault path;
- counts retired instructions.

It sits between the instruction ROM, the ALU and the fetch unit.

---
 rtl/ctrl_pkg.sv | 33 +++
 rtl/ctrl_decode.sv | 50 +++++
 rtl/ctrl_seq.sv | 160 ++++++++++++++++
 tb/tb_ctrl_seq.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the sequential control unit: opcode classes,
// FSM state encoding, decoded-operation kinds and the HALT sub-field.
package ctrl_pkg;

  // Opcode class, taken from the top two bits of the opcode field.
  localparam logic [1:0] OPC_SPECIAL = 2'b00;
  localparam logic [1:0] OPC_ALU     = 2'b01;
  localparam logic [1:0] OPC_LD      = 2'b10;
  localparam logic [1:0] OPC_ST      = 2'b11;

  // A special-class instruction whose operand field is filled entirely
  // with this bit value is a HALT.
  localparam logic HALT_FILL = 1'b1;

  // Sequencer states.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_t;

  // Operation kind produced by the decoder for the current instruction.
  typedef enum logic [2:0] {
    OP_IDLE   = 3'd0,  // no valid instruction this cycle
    OP_NOP    = 3'd1,
    OP_BRANCH = 3'd2,
    OP_HALT   = 3'd3,
    OP_ALU    = 3'd4,
    OP_LOAD   = 3'd5,
    OP_STORE  = 3'd6
  } op_t;

endpackage

// File: rtl/ctrl_decode.sv
// Pure combinational class / sub-op decode of one instruction word.
// Holds no state; the sequencer decides what to do with the result.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int INSTR_W = 9,
  parameter int OPC_W   = 2
) (
  input  logic [INSTR_W-1:0] instr,
  input  logic               valid,
  output op_t                op,
  output logic               br_on_nz
);

  localparam int FIELD_W = INSTR_W - OPC_W;

  logic [1:0]         opc_class;
  logic [FIELD_W-1:0] field;

  // Only the top two opcode bits pick the class; any extra opcode bits
  // fall between the class and the operand field and are ignored.
  assign opc_class = instr[INSTR_W-1 -: 2];
  assign field     = instr[FIELD_W-1:0];

  // Bit 1 of a conditional branch selects "taken when Z is clear".
  assign br_on_nz  = instr[1];

  // Classify the instruction; HALT wins over branch since its pattern has bit 0 set.
  always_comb begin
    // NOTE: default first so every path assigns op and no latch is inferred.
    op = OP_IDLE;
    if (valid) begin
      unique case (opc_class)
        OPC_SPECIAL: begin
          if (field == {FIELD_W{HALT_FILL}}) begin
            op = OP_HALT;
          end else if (instr[0]) begin
            op = OP_BRANCH;
          end else begin
            op = OP_NOP;
          end
        end
        OPC_ALU: op = OP_ALU;
        OPC_LD:  op = OP_LOAD;
        OPC_ST:  op = OP_STORE;
      endcase
    end
  end

endmodule

// File: rtl/ctrl_seq.sv
// Sequential control unit: decodes the current instruction, drives the
// datapath enables, keeps the ALU flags, stalls fetch during memory
// accesses (with a timeout that faults the core) and counts retirements.
module ctrl_seq
  import ctrl_pkg::*;
#(
  parameter int INSTR_W     = 9,
  parameter int OPC_W       = 2,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [INSTR_W-1:0] Instruction,
  input  logic               InstrValid,
  input  logic               AluZero,
  input  logic               AluCarry,
  input  logic               MemAck,
  output logic               BranchEn,
  output logic               RegWrEn,
  output logic               MemRdEn,
  output logic               MemWrEn,
  output logic               PcAdvance,
  output logic               Halt,
  output logic               Fault,
  output logic               FlagZ,
  output logic               FlagC,
  output logic [CNT_W-1:0]   RetireCount
);

  // Wait counter only needs to reach MEM_TIMEOUT-1.
  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t             state;
  logic               flag_z;
  logic               flag_c;
  logic               fault;
  logic [CNT_W-1:0]   retire_cnt;
  logic [WAIT_W-1:0]  wait_cnt;
  logic               pend_store;  // pending access is a store, not a load

  op_t                op;
  logic               br_on_nz;

  logic               branch_en;
  logic               reg_wr_en;
  logic               mem_rd_en;
  logic               mem_wr_en;
  logic               pc_advance;

  ctrl_decode #(
    .INSTR_W (INSTR_W),
    .OPC_W   (OPC_W)
  ) u_decode (
    .instr    (Instruction),
    .valid    (InstrValid),
    .op       (op),
    .br_on_nz (br_on_nz)
  );

  // Same-cycle enables from state, decoded op and the registered flags.
  always_comb begin
    branch_en  = 1'b0;
    reg_wr_en  = 1'b0;
    mem_rd_en  = 1'b0;
    mem_wr_en  = 1'b0;
    pc_advance = 1'b0;
    unique case (state)
      RUN: begin
        unique case (op)
          OP_NOP:    pc_advance = 1'b1;
          OP_BRANCH: begin
            branch_en  = br_on_nz ? ~flag_z : flag_z;
            pc_advance = 1'b1;
          end
          OP_ALU: begin
            reg_wr_en  = 1'b1;
            pc_advance = 1'b1;
          end
          OP_LOAD:   mem_rd_en = 1'b1;
          OP_STORE:  mem_wr_en = 1'b1;
          default:   ;  // idle or HALT: nothing enabled, fetch holds
        endcase
      end
      MEM_WAIT: begin
        // Request stays asserted until the memory acknowledges.
        mem_rd_en = ~pend_store;
        mem_wr_en = pend_store;
        if (MemAck) begin
          pc_advance = 1'b1;
          reg_wr_en  = ~pend_store;
        end
      end
      default: ;  // HALT: everything off
    endcase
  end

  // FSM, flag registers, fault latch and retire counter.
  always_ff @(posedge Clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!Reset) begin
      state      <= RUN;
      flag_z     <= 1'b0;
      flag_c     <= 1'b0;
      fault      <= 1'b0;
      retire_cnt <= '0;
      wait_cnt   <= '0;
      pend_store <= 1'b0;
    end else begin
      if (pc_advance) begin
        retire_cnt <= retire_cnt + 1'b1;
      end
      unique case (state)
        RUN: begin
          unique case (op)
            OP_ALU: begin
              flag_z <= AluZero;
              flag_c <= AluCarry;
            end
            OP_HALT: state <= HALT;
            OP_LOAD, OP_STORE: begin
              state      <= MEM_WAIT;
              wait_cnt   <= '0;
              pend_store <= (op == OP_STORE);
            end
            default: ;
          endcase
        end
        MEM_WAIT: begin
          // An ack on the last allowed cycle still completes normally.
          if (MemAck) begin
            state <= RUN;
          end else if (wait_cnt == WAIT_LAST) begin
            fault <= 1'b1;
            state <= HALT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        HALT: ;  // sticky until reset
        default: state <= RUN;
      endcase
    end
  end

  // Every output reads as zero while reset is held low; this also aborts
  // an outstanding memory request in the very cycle reset is asserted.
  assign BranchEn    = Reset & branch_en;
  assign RegWrEn     = Reset & reg_wr_en;
  assign MemRdEn     = Reset & mem_rd_en;
  assign MemWrEn     = Reset & mem_wr_en;
  assign PcAdvance   = Reset & pc_advance;
  assign Halt        = Reset & (state == HALT);
  assign Fault       = Reset & fault;
  assign FlagZ       = Reset & flag_z;
  assign FlagC       = Reset & flag_c;
  assign RetireCount = Reset ? retire_cnt : '0;

endmodule

// File: tb/tb_ctrl_seq.sv
// Scoreboard bench for ctrl_seq: the stimulus process computes each cycle's
// expected outputs from a behavioural model and queues them; a monitor
// samples the DUT on the falling edge and compares against the queue.
module tb_ctrl_seq;

  localparam int INSTR_W     = 9;
  localparam int OPC_W       = 2;
  localparam int MEM_TIMEOUT = 15;
  localparam int CNT_W       = 16;

  logic               Clk = 1'b0;
  logic               Reset = 1'b0;
  logic [INSTR_W-1:0] Instruction = '0;
  logic               InstrValid = 1'b0;
  logic               AluZero = 1'b0;
  logic               AluCarry = 1'b0;
  logic               MemAck = 1'b0;
  logic               BranchEn, RegWrEn, MemRdEn, MemWrEn, PcAdvance;
  logic               Halt, Fault, FlagZ, FlagC;
  logic [CNT_W-1:0]   RetireCount;

  ctrl_seq #(
    .INSTR_W     (INSTR_W),
    .OPC_W       (OPC_W),
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Instruction (Instruction),
    .InstrValid  (InstrValid),
    .AluZero     (AluZero),
    .AluCarry    (AluCarry),
    .MemAck      (MemAck),
    .BranchEn    (BranchEn),
    .RegWrEn     (RegWrEn),
    .MemRdEn     (MemRdEn),
    .MemWrEn     (MemWrEn),
    .PcAdvance   (PcAdvance),
    .Halt        (Halt),
    .Fault       (Fault),
    .FlagZ       (FlagZ),
    .FlagC       (FlagC),
    .RetireCount (RetireCount)
  );

  always #5 Clk = ~Clk;

  // Output bundle: {br, rw, rd, wr, pc, halt, fault, z, c} plus the count.
  typedef struct packed {
    logic [8:0]       bits;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model of the core's control view.
  bit          m_halted = 0;
  bit          m_busy   = 0;   // memory access outstanding
  bit          m_store  = 0;
  int          m_waits  = 0;   // un-acked cycles spent waiting so far
  bit          m_z = 0, m_c = 0, m_fault = 0;
  int unsigned m_cnt = 0;

  localparam logic [8:0] I_NOP  = 9'b000000010;
  localparam logic [8:0] I_BRZ  = 9'b000000001;
  localparam logic [8:0] I_BRNZ = 9'b000000011;
  localparam logic [8:0] I_ALU  = 9'b010110101;
  localparam logic [8:0] I_LD   = 9'b100000100;
  localparam logic [8:0] I_ST   = 9'b110001000;
  localparam logic [8:0] I_HALT = 9'b001111111;

  // Apply one cycle of inputs, queue the expected outputs, advance the model.
  task automatic drive(input bit rst, input logic [8:0] ins, input bit v,
                       input bit z, input bit c, input bit ack, input string tag);
    bit br, rw, rd, wr, pc;
    int cls, low;
    exp_t e;
    @(posedge Clk);
    #1;
    Reset = rst; Instruction = ins; InstrValid = v;
    AluZero = z; AluCarry = c; MemAck = ack;
    br = 0; rw = 0; rd = 0; wr = 0; pc = 0;
    if (!rst) begin
      e = '0;
      exp_q.push_back(e);
      tag_q.push_back(tag);
      m_halted = 0; m_busy = 0; m_store = 0; m_waits = 0;
      m_z = 0; m_c = 0; m_fault = 0; m_cnt = 0;
      return;
    end
    e.cnt  = CNT_W'(m_cnt);
    e.bits = {5'b0, m_halted, m_fault, m_z, m_c};
    if (m_halted) begin
      // nothing moves
    end else if (m_busy) begin
      rd = !m_store; wr = m_store;
      if (ack) begin
        pc = 1; rw = !m_store; m_busy = 0;
      end else begin
        m_waits++;
        if (m_waits == MEM_TIMEOUT) begin
          m_fault = 1; m_halted = 1; m_busy = 0;
        end
      end
    end else if (v) begin
      cls = int'(ins) / 128;
      low = int'(ins) % 128;
      case (cls)
        0: begin
          if (low == 127) m_halted = 1;
          else if (low % 2 == 1) begin
            pc = 1;
            br = ((low / 2) % 2 == 1) ? !m_z : m_z;
          end else pc = 1;
        end
        1: begin rw = 1; pc = 1; m_z = z; m_c = c; end
        2: begin rd = 1; m_busy = 1; m_store = 0; m_waits = 0; end
        default: begin wr = 1; m_busy = 1; m_store = 1; m_waits = 0; end
      endcase
    end
    e.bits[8:4] = {br, rw, rd, wr, pc};
    if (pc) m_cnt = (m_cnt + 1) % (1 << CNT_W);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // Monitor: compare the DUT against the oldest queued expectation.
  initial begin
    forever begin
      exp_t  want, got;
      string tag;
      @(negedge Clk);
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        tag  = tag_q.pop_front();
        got.bits = {BranchEn, RegWrEn, MemRdEn, MemWrEn, PcAdvance,
                    Halt, Fault, FlagZ, FlagC};
        got.cnt  = RetireCount;
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s @%0t: got {br,rw,rd,wr,pc,halt,fault,z,c}=%b cnt=%0d, want %b cnt=%0d",
                      tag, $time, got.bits, got.cnt, want.bits, want.cnt);
      end
    end
  end

  initial begin
    bit          rst, v, ack, slow;
    logic [8:0]  ins;
    int          cls, low;

    // Reset, idle, first NOP.
    drive(0, I_NOP, 1, 0, 0, 1, "reset0");
    drive(0, I_ALU, 1, 1, 1, 1, "reset1");
    drive(1, I_NOP, 0, 0, 0, 0, "idle");
    drive(1, I_NOP, 1, 0, 0, 0, "first_nop");

    // Flag / branch pairs, both polarities.
    drive(1, I_ALU,  1, 1, 1, 0, "alu_z1");
    drive(1, I_BRZ,  1, 0, 0, 0, "brz_after_z1");
    drive(1, I_ALU,  1, 0, 0, 0, "alu_z0");
    drive(1, I_BRZ,  1, 1, 1, 0, "brz_after_z0");
    drive(1, I_ALU,  1, 1, 0, 0, "alu_z1b");
    drive(1, I_BRNZ, 1, 0, 1, 0, "brnz_after_z1");
    drive(1, I_ALU,  1, 0, 1, 0, "alu_z0b");
    drive(1, I_BRNZ, 1, 0, 0, 0, "brnz_after_z0");

    // Load: ack in the issue cycle is ignored, then two waits, then ack.
    drive(1, I_LD,  1, 1, 1, 1, "ld_issue");
    drive(1, I_ALU, 1, 1, 1, 0, "ld_wait1");
    drive(1, I_ALU, 1, 1, 1, 0, "ld_wait2");
    drive(1, I_ALU, 1, 1, 1, 1, "ld_ack");

    // Store acked on the last allowed cycle: completes, no fault.
    drive(1, I_ST, 1, 0, 0, 0, "st_edge_issue");
    for (int i = 0; i < MEM_TIMEOUT - 1; i++) drive(1, I_NOP, 1, 0, 0, 0, "st_edge_wait");
    drive(1, I_NOP, 1, 0, 0, 1, "st_edge_ack");
    drive(1, I_NOP, 1, 0, 0, 0, "st_edge_after");

    // Store never acked: fault and sticky halt.
    drive(1, I_ST, 1, 0, 0, 0, "st_to_issue");
    for (int i = 0; i < MEM_TIMEOUT; i++) drive(1, I_NOP, 1, 0, 0, 0, "st_to_wait");
    for (int i = 0; i < 4; i++) drive(1, I_ALU, 1, 1, 1, 1, "faulted_halt");
    drive(0, I_NOP, 0, 0, 0, 0, "reset_clear_fault");

    // HALT instruction, then ALU ops that must not write.
    drive(1, I_HALT, 1, 0, 0, 0, "halt_instr");
    for (int i = 0; i < 3; i++) drive(1, I_ALU, 1, 1, 1, 0, "halted_alu");
    drive(0, I_NOP, 0, 0, 0, 0, "reset_clear_halt");

    // Reset in the middle of a load drops the request immediately.
    drive(1, I_LD,  1, 0, 0, 0, "ld_abort_issue");
    drive(1, I_NOP, 1, 0, 0, 0, "ld_abort_wait");
    drive(0, I_NOP, 1, 0, 0, 0, "ld_abort_reset");
    drive(1, I_NOP, 1, 0, 0, 0, "after_abort_nop");

    // Randomised traffic; slow phases make timeouts reachable.
    slow = 0;
    for (int n = 0; n < 3000; n++) begin
      if (n % 100 == 0) slow = ($urandom_range(0, 2) == 0);
      rst = !((m_halted && $urandom_range(0, 7) == 0) || $urandom_range(0, 99) == 0);
      cls = int'($urandom_range(0, 3));
      low = int'($urandom_range(0, 127));
      if (cls == 0) begin
        if ($urandom_range(0, 39) == 0) low = 127;
        else if (low == 127) low = 126;
      end
      ins = 9'(cls * 128 + low);
      v   = ($urandom_range(0, 4) != 0);
      ack = slow ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 2) == 0);
      drive(rst, ins, v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ack, "random");
    end

    @(negedge Clk);
    #1;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
